// File: rtl/sram_pkg.sv
// Shared types and constants for the on-chip SRAM stand-in.
package sram_pkg;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;
    localparam int BYTE_LO = 0;
    localparam int BYTE_HI = 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } state_t;

endpackage

// File: rtl/sram_byte_mem.sv
// 2**AW x 16 synchronous RAM with per-byte write enables and a registered read port.
module sram_byte_mem
    import sram_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic               clk,
    input  logic [1:0]         we,
    input  logic [AW-1:0]      waddr,
    input  logic [SRAM_DW-1:0] wdata,
    input  logic               re,
    input  logic [AW-1:0]      raddr,
    output logic [SRAM_DW-1:0] rdata
);

    // Split byte arrays keep the byte-enable write inferable as block RAM.
    logic [7:0] mem_hi [0:(1<<AW)-1];
    logic [7:0] mem_lo [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we[BYTE_HI]) mem_hi[waddr] <= wdata[15:8];
        if (we[BYTE_LO]) mem_lo[waddr] <= wdata[7:0];
        if (re)          rdata <= {mem_hi[raddr], mem_lo[raddr]};
    end

endmodule

// File: rtl/sram_responder.sv
// Answers the async-SRAM pin protocol from on-chip RAM; tracks access counts and
// flags protocol violations.
module sram_responder
    import sram_pkg::*;
#(
    parameter int MEM_AW = 12,
    parameter int CNT_W  = 16
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    inout  logic [SRAM_DW-1:0] SRAM_DQ,
    input  logic [SRAM_AW-1:0] SRAM_ADDR,
    input  logic               SRAM_WE_N,
    input  logic               SRAM_OE_N,
    input  logic               SRAM_UB_N,
    input  logic               SRAM_LB_N,
    input  logic               SRAM_CE_N,
    output logic [CNT_W-1:0]   rd_count,
    output logic [CNT_W-1:0]   wr_count,
    output logic               proto_err
);

    state_t             state;
    logic               sel, wr, rd;
    logic [MEM_AW-1:0]  lat_addr;
    logic [SRAM_DW-1:0] lat_data;
    logic               lat_ub_n, lat_lb_n;
    logic [SRAM_AW-1:0] prev_addr;
    logic               rd_q;
    logic [1:0]         fwd_q;
    logic [SRAM_DW-1:0] fwd_data_q;
    logic [SRAM_DW-1:0] ram_q, rd_data;
    logic               commit, addr_chg, same_word, rd_inc, viol;
    logic [1:0]         commit_be;
    logic               drv_hi, drv_lo;

    assign sel = !SRAM_CE_N;
    assign wr  = sel && !SRAM_WE_N;
    assign rd  = sel && SRAM_WE_N && !SRAM_OE_N;

    assign commit    = (state == WRITE) && !wr;
    assign commit_be = {!lat_ub_n, !lat_lb_n} & {2{commit}};
    assign addr_chg  = SRAM_ADDR != prev_addr;
    assign same_word = lat_addr == SRAM_ADDR[MEM_AW-1:0];
    assign rd_inc    = rd && ((state != READ) || addr_chg);
    assign viol      = ((state == WRITE) && wr && addr_chg)
                     || ((rd || wr) && SRAM_UB_N && SRAM_LB_N);

    sram_byte_mem #(.AW(MEM_AW)) u_mem (
        .clk   (CLOCK_50),
        .we    (commit_be),
        .waddr (lat_addr),
        .wdata (lat_data),
        .re    (rd),
        .raddr (SRAM_ADDR[MEM_AW-1:0]),
        .rdata (ram_q)
    );

    // Lanes committed in the same cycle they were read bypass the RAM's old data.
    assign rd_data = {fwd_q[BYTE_HI] ? fwd_data_q[15:8] : ram_q[15:8],
                      fwd_q[BYTE_LO] ? fwd_data_q[7:0]  : ram_q[7:0]};

    assign drv_hi = rd_q && rd && !SRAM_UB_N;
    assign drv_lo = rd_q && rd && !SRAM_LB_N;
    assign SRAM_DQ[15:8] = drv_hi ? rd_data[15:8] : 'z;
    assign SRAM_DQ[7:0]  = drv_lo ? rd_data[7:0]  : 'z;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            rd_q       <= 1'b0;
            fwd_q      <= '0;
            fwd_data_q <= '0;
            lat_addr   <= '0;
            lat_data   <= '0;
            lat_ub_n   <= 1'b1;
            lat_lb_n   <= 1'b1;
            prev_addr  <= '0;
            rd_count   <= '0;
            wr_count   <= '0;
            proto_err  <= 1'b0;
        end else begin
            rd_q      <= rd;
            prev_addr <= SRAM_ADDR;
            if (wr) begin
                lat_addr <= SRAM_ADDR[MEM_AW-1:0];
                lat_data <= SRAM_DQ;
                lat_ub_n <= SRAM_UB_N;
                lat_lb_n <= SRAM_LB_N;
            end
            if (rd) begin
                fwd_q      <= commit_be & {2{same_word}};
                fwd_data_q <= lat_data;
            end
            if (rd_inc && (rd_count != '1))
                rd_count <= rd_count + 1'b1;
            if ((commit_be != 2'b00) && (wr_count != '1))
                wr_count <= wr_count + 1'b1;
            if (viol)
                proto_err <= 1'b1;
            case (state)
                IDLE:    if (wr) state <= WRITE;
                         else if (rd) state <= READ;
                WRITE:   if (!wr) state <= rd ? READ : IDLE;
                READ:    if (wr) state <= WRITE;
                         else if (!rd) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Directed scoreboard bench for sram_responder; released DQ lanes read as 1 via tri1.
module tb_sram_responder;

    localparam int CNT_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    tri1 [15:0]        sram_dq;
    logic [17:0]       addr;
    logic              we_n, oe_n, ub_n, lb_n, ce_n;
    logic [CNT_W-1:0]  rd_count, wr_count;
    logic              proto_err;
    logic [15:0]       tb_dq;
    logic              tb_dq_en;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [15:0] model [0:4095];
    logic [15:0] sb_q [$];
    logic [15:0] exp_v;

    assign sram_dq = tb_dq_en ? tb_dq : 'z;

    always #5 clk = ~clk;

    sram_responder #(.MEM_AW(12), .CNT_W(CNT_W)) dut (
        .CLOCK_50  (clk),
        .RESET     (rst),
        .SRAM_DQ   (sram_dq),
        .SRAM_ADDR (addr),
        .SRAM_WE_N (we_n),
        .SRAM_OE_N (oe_n),
        .SRAM_UB_N (ub_n),
        .SRAM_LB_N (lb_n),
        .SRAM_CE_N (ce_n),
        .rd_count  (rd_count),
        .wr_count  (wr_count),
        .proto_err (proto_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_dq(input logic [17:0] a, input logic u, input logic l);
        logic [15:0] m;
        m = model[a[11:0]];
        return {u ? 8'hFF : m[15:8], l ? 8'hFF : m[7:0]};
    endfunction

    task automatic end_op();
        we_n = 1'b1; oe_n = 1'b1; ce_n = 1'b1; tb_dq_en = 1'b0;
        step();
    endtask

    task automatic do_write(input logic [17:0] a, input logic [15:0] d,
                            input logic u, input logic l, input int unsigned n);
        logic [15:0] m;
        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = a; ub_n = u; lb_n = l;
        tb_dq = d; tb_dq_en = 1'b1;
        repeat (n) step();
        end_op();
        m = model[a[11:0]];
        if (!u) m[15:8] = d[15:8];
        if (!l) m[7:0]  = d[7:0];
        model[a[11:0]] = m;
    endtask

    task automatic read_check(input string tag, input logic [17:0] a,
                              input logic u, input logic l);
        ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; addr = a; ub_n = u; lb_n = l;
        tb_dq_en = 1'b0;
        sb_q.push_back(exp_dq(a, u, l));
        step();
        exp_v = sb_q.pop_front();
        chk(tag, {16'h0, sram_dq}, {16'h0, exp_v});
        end_op();
        ub_n = 1'b0; lb_n = 1'b0;
    endtask

    task automatic reset_pulse();
        ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; tb_dq_en = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; ub_n = 1'b0; lb_n = 1'b0;
        addr = '0; tb_dq = '0; tb_dq_en = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("reset_rd_count", {24'h0, rd_count}, 32'd0);
        chk("reset_wr_count", {24'h0, wr_count}, 32'd0);
        chk("reset_proto_err", {31'h0, proto_err}, 32'd0);
        chk("reset_dq_released", {16'h0, sram_dq}, 32'h0000FFFF);

        // Test 1: reset in the middle of a write discards it.
        do_write(18'd5, 16'h0000, 1'b0, 1'b0, 1);
        chk("t1_seed_wr_count", {24'h0, wr_count}, 32'd1);
        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = 18'd5; tb_dq = 16'hBEEF; tb_dq_en = 1'b1;
        step();
        #2;
        rst = 1'b1; we_n = 1'b1; oe_n = 1'b0; tb_dq_en = 1'b0;
        #1;
        chk("t1_async_wr_count", {24'h0, wr_count}, 32'd0);
        chk("t1_dq_z_in_reset", {16'h0, sram_dq}, 32'h0000FFFF);
        step();
        chk("t1_dq_z_in_reset_edge", {16'h0, sram_dq}, 32'h0000FFFF);
        ce_n = 1'b1; oe_n = 1'b1;
        rst = 1'b0;
        step();
        read_check("t1_no_commit", 18'd5, 1'b0, 1'b0);
        chk("t1_wr_count", {24'h0, wr_count}, 32'd0);

        // Test 2: plain write then read.
        reset_pulse();
        do_write(18'h0000A, 16'h1234, 1'b0, 1'b0, 2);
        read_check("t2_read", 18'h0000A, 1'b0, 1'b0);
        chk("t2_wr_count", {24'h0, wr_count}, 32'd1);
        chk("t2_rd_count", {24'h0, rd_count}, 32'd1);

        // Test 3: byte lanes.
        do_write(18'd3, 16'hAAAA, 1'b0, 1'b0, 1);
        do_write(18'd3, 16'h5555, 1'b1, 1'b0, 1);
        read_check("t3_merge", 18'd3, 1'b0, 1'b0);
        read_check("t3_lb_off", 18'd3, 1'b0, 1'b1);
        chk("t3_wr_count", {24'h0, wr_count}, 32'd3);
        chk("t3_rd_count", {24'h0, rd_count}, 32'd3);

        // Test 4: write exiting straight into a read of the same word.
        do_write(18'd7, 16'h1111, 1'b0, 1'b0, 1);
        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b0; addr = 18'd7; tb_dq = 16'h0F0F; tb_dq_en = 1'b1;
        step();
        step();
        we_n = 1'b1; tb_dq_en = 1'b0;
        model[7] = 16'h0F0F;
        sb_q.push_back(exp_dq(18'd7, 1'b0, 1'b0));
        step();
        exp_v = sb_q.pop_front();
        chk("t4_forward", {16'h0, sram_dq}, {16'h0, exp_v});
        end_op();
        chk("t4_wr_count", {24'h0, wr_count}, 32'd5);
        chk("t4_rd_count", {24'h0, rd_count}, 32'd4);

        // Test 5: upper address bits alias.
        do_write(18'h01000, 16'hCAFE, 1'b0, 1'b0, 1);
        read_check("t5_alias", 18'h00000, 1'b0, 1'b0);
        chk("t5_no_false_err", {31'h0, proto_err}, 32'd0);

        // Test 6: protocol violations.
        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = 18'd8; tb_dq = 16'h2222; tb_dq_en = 1'b1;
        step();
        addr = 18'd9;
        step();
        chk("t6_addr_change_err", {31'h0, proto_err}, 32'd1);
        end_op();
        model[9] = 16'h2222;
        repeat (3) step();
        read_check("t6_last_addr_wins", 18'd9, 1'b0, 1'b0);
        chk("t6_err_sticky", {31'h0, proto_err}, 32'd1);
        reset_pulse();
        chk("t6_err_cleared", {31'h0, proto_err}, 32'd0);
        do_write(18'd2, 16'h7777, 1'b1, 1'b1, 1);
        chk("t6_no_lane_err", {31'h0, proto_err}, 32'd1);
        chk("t6_no_lane_no_count", {24'h0, wr_count}, 32'd0);
        ub_n = 1'b0; lb_n = 1'b0;
        reset_pulse();

        // Counter saturation.
        ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0;
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            addr = {17'h0, i[0]};
            step();
            if (i == 9) chk("sat_rd_mid", {24'h0, rd_count}, 32'd10);
        end
        end_op();
        chk("sat_rd_count", {24'h0, rd_count}, 32'h000000FF);
        for (int i = 0; i < (1 << CNT_W) + 4; i++) begin
            do_write(18'(i + 16), 16'(i * 3), 1'b0, 1'b0, 1);
        end
        chk("sat_wr_count", {24'h0, wr_count}, 32'h000000FF);
        read_check("sat_last_data", 18'(16 + (1 << CNT_W) + 3), 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
